// File: rtl/ast_width_downsizer_pkg.sv
// Shared widths, types and FSM constants for the 256->64 Avalon-ST width downsizer.
package ast_width_downsizer_pkg;

  localparam int DATA_IN_W   = 256;
  localparam int DATA_OUT_W  = 64;
  localparam int CHANNEL_W   = 10;
  localparam int BYTES_IN    = DATA_IN_W / 8;
  localparam int BYTES_OUT   = DATA_OUT_W / 8;
  localparam int EMPTY_IN_W  = (BYTES_IN > 1) ? $clog2(BYTES_IN) : 1;
  localparam int EMPTY_OUT_W = (BYTES_OUT > 1) ? $clog2(BYTES_OUT) : 1;
  localparam int RATIO       = DATA_IN_W / DATA_OUT_W;
  localparam int IDX_W       = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef logic [CHANNEL_W-1:0]   channel_t;
  typedef logic [EMPTY_IN_W-1:0]  empty_in_t;
  typedef logic [EMPTY_OUT_W-1:0] empty_out_t;
  typedef logic [IDX_W-1:0]       word_idx_t;
  typedef logic [0:0]             state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SEND = 1'b1;

endpackage

// File: rtl/ast_width_downsizer_tail_calc.sv
// Combinational tail math: from a beat's eop/empty, the index of its last emitted word
// and the number of unused bytes in that word.
module ast_downsizer_tail_calc
  import ast_width_downsizer_pkg::*;
(
  input  logic       eop,
  input  empty_in_t  empty,
  output word_idx_t  last_idx,
  output empty_out_t last_empty
);

  int vb_m1;

  // vb_m1 is the byte offset of the last valid byte in the beat.
  always_comb begin
    vb_m1 = BYTES_IN - 1;
    if (eop) vb_m1 = BYTES_IN - 1 - int'(empty);
    last_idx   = word_idx_t'(vb_m1 / BYTES_OUT);
    last_empty = eop ? empty_out_t'(BYTES_OUT - 1 - (vb_m1 % BYTES_OUT)) : '0;
  end

endmodule

// File: rtl/ast_width_downsizer.sv
// Avalon-ST 256->64 width downsizer: holds one wide beat and streams it out word 0 first.
// Optional protocol checker enabled by defining AST_DOWNSIZER_PROTO_CHECK_EN.
module ast_width_downsizer
  import ast_width_downsizer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [DATA_IN_W-1:0]  ast_data_i,
  input  logic                  ast_startofpacket_i,
  input  logic                  ast_endofpacket_i,
  input  logic                  ast_valid_i,
  input  logic [EMPTY_IN_W-1:0] ast_empty_i,
  input  logic [CHANNEL_W-1:0]  ast_channel_i,
  output logic                  ast_ready_o,
  output logic [DATA_OUT_W-1:0] ast_data_o,
  output logic                  ast_startofpacket_o,
  output logic                  ast_endofpacket_o,
  output logic                  ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]  ast_channel_o,
  input  logic                  ast_ready_i,
  output logic                  err_o
);

  state_t                 state_q;
  logic [DATA_IN_W-1:0]   beat_q;
  word_idx_t              idx_q;
  word_idx_t              last_idx_q;
  empty_out_t             last_empty_q;
  logic                   sop_q;
  logic                   eop_q;
  channel_t               channel_q;

  word_idx_t              calc_last_idx;
  empty_out_t             calc_last_empty;
  logic                   in_xfer;
  logic                   out_xfer;
  logic                   last_word;

  ast_downsizer_tail_calc u_tail_calc (
    .eop        (ast_endofpacket_i),
    .empty      (ast_empty_i),
    .last_idx   (calc_last_idx),
    .last_empty (calc_last_empty)
  );

  assign last_word   = (idx_q == last_idx_q);
  assign out_xfer    = ast_valid_o & ast_ready_i;
  assign ast_ready_o = !srst_i & ((state_q == ST_IDLE) | (out_xfer & last_word));
  assign in_xfer     = ast_valid_i & ast_ready_o;

  // A new beat is only accepted when the held one is done, so loading always restarts at word 0.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      last_empty_q <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      channel_q    <= '0;
    end else if (in_xfer) begin
      state_q      <= ST_SEND;
      beat_q       <= ast_data_i;
      idx_q        <= '0;
      last_idx_q   <= calc_last_idx;
      last_empty_q <= calc_last_empty;
      sop_q        <= ast_startofpacket_i;
      eop_q        <= ast_endofpacket_i;
      channel_q    <= ast_channel_i;
    end else if (out_xfer) begin
      if (last_word) state_q <= ST_IDLE;
      else           idx_q   <= idx_q + 1'b1;
    end
  end

  assign ast_valid_o         = (state_q == ST_SEND);
  assign ast_data_o          = beat_q[int'(idx_q)*DATA_OUT_W +: DATA_OUT_W];
  assign ast_startofpacket_o = ast_valid_o & sop_q & (idx_q == '0);
  assign ast_endofpacket_o   = ast_valid_o & eop_q & last_word;
  assign ast_empty_o         = ast_endofpacket_o ? last_empty_q : '0;
  assign ast_channel_o       = channel_q;

`ifdef AST_DOWNSIZER_PROTO_CHECK_EN
  logic     pkt_open_q;
  channel_t open_channel_q;
  logic     err_q;
  logic     proto_viol;

  always_comb begin
    proto_viol = 1'b0;
    if (ast_startofpacket_i && pkt_open_q)                       proto_viol = 1'b1;
    if (!ast_startofpacket_i && !pkt_open_q)                     proto_viol = 1'b1;
    if (pkt_open_q && (ast_channel_i != open_channel_q))         proto_viol = 1'b1;
    if (!ast_endofpacket_i && (ast_empty_i != '0))               proto_viol = 1'b1;
  end

  // Violations are only flagged; the beat itself is forwarded untouched.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pkt_open_q     <= 1'b0;
      open_channel_q <= '0;
      err_q          <= 1'b0;
    end else if (in_xfer) begin
      pkt_open_q     <= !ast_endofpacket_i;
      open_channel_q <= ast_channel_i;
      if (proto_viol) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ast_width_downsizer.sv
// Self-checking bench for ast_width_downsizer: queue-based word model plus directed literal checks.
module tb_ast_width_downsizer;
  import ast_width_downsizer_pkg::*;

  logic                   clk = 1'b0;
  logic                   srst = 1'b1;
  logic [DATA_IN_W-1:0]   data_i = '0;
  logic                   sop_i = 1'b0;
  logic                   eop_i = 1'b0;
  logic                   valid_i = 1'b0;
  logic [EMPTY_IN_W-1:0]  empty_i = '0;
  logic [CHANNEL_W-1:0]   channel_i = '0;
  logic                   ready_o;
  logic [DATA_OUT_W-1:0]  data_o;
  logic                   sop_o;
  logic                   eop_o;
  logic                   valid_o;
  logic [EMPTY_OUT_W-1:0] empty_o;
  logic [CHANNEL_W-1:0]   channel_o;
  logic                   ready_i = 1'b1;
  logic                   err_o;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ready_pct = 100;
  int last_accept_cyc = 0;
  logic err_test = 1'b0;

  typedef struct packed {
    logic [DATA_OUT_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_OUT_W-1:0] empty;
    logic [CHANNEL_W-1:0]   ch;
  } word_t;

  word_t exp_q[$];
  word_t out_log[$];
  int    out_cyc[$];
  word_t prev_word;
  logic  prev_stall = 1'b0;

  ast_width_downsizer dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .ast_data_i          (data_i),
    .ast_startofpacket_i (sop_i),
    .ast_endofpacket_i   (eop_i),
    .ast_valid_i         (valid_i),
    .ast_empty_i         (empty_i),
    .ast_channel_i       (channel_i),
    .ast_ready_o         (ready_o),
    .ast_data_o          (data_o),
    .ast_startofpacket_o (sop_o),
    .ast_endofpacket_o   (eop_o),
    .ast_valid_o         (valid_o),
    .ast_empty_o         (empty_o),
    .ast_channel_o       (channel_o),
    .ast_ready_i         (ready_i),
    .err_o               (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    ready_i = ($urandom_range(99) < ready_pct);
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a beat carries vb valid bytes and becomes ceil(vb/8) words.
  function automatic void modelBeat(input logic [DATA_IN_W-1:0] d, input logic s, input logic e,
                                    input logic [EMPTY_IN_W-1:0] em, input logic [CHANNEL_W-1:0] c);
    int vb;
    int nw;
    word_t w;
    vb = e ? (BYTES_IN - int'(em)) : BYTES_IN;
    nw = (vb + BYTES_OUT - 1) / BYTES_OUT;
    for (int k = 0; k < nw; k++) begin
      w.data  = d[k*DATA_OUT_W +: DATA_OUT_W];
      w.sop   = s && (k == 0);
      w.eop   = e && (k == nw - 1);
      w.empty = (e && (k == nw - 1)) ? EMPTY_OUT_W'(nw*BYTES_OUT - vb) : '0;
      w.ch    = c;
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    word_t cur;
    cur = {data_o, sop_o, eop_o, empty_o, channel_o};
    if (srst) begin
      checkOutput("ready_in_reset", ready_o, 1'b0);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      checkOutput("valid_o", valid_o, exp_q.size() > 0);
      checkOutput("ready_o", ready_o, (exp_q.size() == 0) || (exp_q.size() == 1 && ready_i));
      if (!err_test) checkOutput("err_o_idle", err_o, 1'b0);
      if (prev_stall) checkOutput("stall_stable", cur, prev_word);
      if (valid_o && ready_i) begin
        if (exp_q.size() > 0) begin
          checkOutput("word", cur, exp_q[0]);
          exp_q.pop_front();
        end
        out_log.push_back(cur);
        out_cyc.push_back(cyc);
      end
      if (valid_i && ready_o) modelBeat(data_i, sop_i, eop_i, empty_i, channel_i);
      prev_stall = valid_o && !ready_i;
      prev_word  = cur;
    end
  end

  task automatic applyStimulus(input logic [DATA_IN_W-1:0] d, input logic s, input logic e,
                               input logic [EMPTY_IN_W-1:0] em, input logic [CHANNEL_W-1:0] c,
                               input int idle_pct);
    bit done;
    while ($urandom_range(99) < idle_pct) begin
      valid_i = 1'b0;
      @(posedge clk); #1;
    end
    data_i = d; sop_i = s; eop_i = e; empty_i = em; channel_i = c;
    valid_i = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (ready_o) begin
        done = 1'b1;
        last_accept_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) checkOutput("accept_timeout", 1'b0, 1'b1);
    valid_i = 1'b0;
  endtask

  task automatic sendPacket(input int nbytes, input logic [CHANNEL_W-1:0] ch, input int idle_pct);
    int nbeats;
    logic [DATA_IN_W-1:0] d;
    nbeats = (nbytes + BYTES_IN - 1) / BYTES_IN;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < DATA_IN_W/32; j++) d[j*32 +: 32] = $urandom;
      applyStimulus(d, b == 0, b == nbeats - 1,
                    (b == nbeats - 1) ? EMPTY_IN_W'(nbeats*BYTES_IN - nbytes) : '0, ch, idle_pct);
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulseReset();
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  initial begin
    logic [DATA_IN_W-1:0] d;
    int base;

    repeat (2) @(posedge clk);
    #1; srst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_sop_eop", {sop_o, eop_o}, 2'b00);
    checkOutput("rst_empty", empty_o, 0);
    checkOutput("rst_channel", channel_o, 0);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_err", err_o, 1'b0);
    @(posedge clk); #1;

    $display("[TB] single-beat packet, words 0..3");
    out_log.delete(); out_cyc.delete();
    d = {64'h3, 64'h2, 64'h1, 64'h0};
    applyStimulus(d, 1'b1, 1'b1, '0, 10'd3, 0);
    waitDrain();
    checkOutput("t1_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) checkOutput("t1_data", out_log[k].data, k);
      checkOutput("t1_sop", {out_log[0].sop, out_log[1].sop, out_log[3].sop}, 3'b100);
      checkOutput("t1_eop", {out_log[2].eop, out_log[3].eop}, 2'b01);
      checkOutput("t1_empty", out_log[3].empty, 0);
      checkOutput("t1_back2back", out_cyc[3] - out_cyc[0], 3);
    end

    $display("[TB] two-beat packet, 19 bytes in last beat");
    out_log.delete(); out_cyc.delete();
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    applyStimulus(d, 1'b1, 1'b0, '0, 10'd7, 0);
    base = last_accept_cyc;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    applyStimulus(d, 1'b0, 1'b1, 5'd13, 10'd7, 0);
    checkOutput("t2_accept_gap", last_accept_cyc - base, 4);
    waitDrain();
    checkOutput("t2_count", out_log.size(), 7);
    if (out_log.size() == 7) begin
      checkOutput("t2_last_empty", out_log[6].empty, 5);
      checkOutput("t2_last_eop", {out_log[3].eop, out_log[6].eop}, 2'b01);
      checkOutput("t2_last_data", out_log[6].data, d[2*DATA_OUT_W +: DATA_OUT_W]);
    end

    $display("[TB] three packets back-to-back, ready 50 percent");
    ready_pct = 50;
    for (int p = 0; p < 3; p++) sendPacket($urandom_range(1, 96), 10'($urandom), 0);
    waitDrain();

    $display("[TB] random packets with idles and stalls");
    ready_pct = 70;
    for (int p = 0; p < 200; p++) sendPacket($urandom_range(1, 256), 10'($urandom), 20);
    waitDrain();
    ready_pct = 100;
    @(posedge clk); #1;

    $display("[TB] reset mid-beat");
    out_log.delete();
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    applyStimulus(d, 1'b1, 1'b1, '0, 10'd9, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulseReset();
    @(negedge clk);
    checkOutput("t4_valid_after_rst", valid_o, 1'b0);
    checkOutput("t4_ready_after_rst", ready_o, 1'b1);
    checkOutput("t4_words_before_rst", out_log.size(), 2);
    @(posedge clk); #1;
    out_log.delete();
    sendPacket(40, 10'd11, 0);
    waitDrain();
    checkOutput("t4_next_packet_words", out_log.size(), 5);

    $display("[TB] protocol error flag");
    err_test = 1'b1;
    applyStimulus(d, 1'b0, 1'b1, '0, 10'd5, 0);
    @(negedge clk);
`ifdef AST_DOWNSIZER_PROTO_CHECK_EN
    checkOutput("t5_err_set", err_o, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5_err_sticky", err_o, 1'b1);
    waitDrain();
    pulseReset();
    @(negedge clk);
    checkOutput("t5_err_cleared", err_o, 1'b0);
`else
    checkOutput("t5_err_tied_low", err_o, 1'b0);
    waitDrain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
